// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES job sequencer: mode encodings, FSM states
// and default parameter values.
package aes_seq_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int TMO_W_DEF   = 16;
    localparam int TMO_MAX_DEF = 5000;
    localparam int STAT_W_DEF  = 16;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_LOOP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENC_RUN = 2'd1,
        DEC_RUN = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/aes_seq_timer.sv
// Per-operation watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count sits at TMO_MAX-1.
module aes_seq_timer
    import aes_seq_pkg::*;
#(
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] r_cnt;

    // Holds at the limit so a late expire stays asserted instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/aes_seq_ctrl.sv
// Single-job sequencer for the AES encrypt/decrypt cores (encrypt, decrypt,
// loopback) with timeout abort. Optional counters: AES_SEQ_STATS_EN.
module aes_seq_ctrl
    import aes_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [DATA_W-1:0]   in_key,
    input  logic [DATA_W-1:0]   in_data,
    output logic                enc_start,
    output logic [DATA_W-1:0]   enc_key,
    output logic [DATA_W-1:0]   enc_din,
    input  logic                enc_done,
    input  logic [DATA_W-1:0]   enc_dout,
    output logic                dec_start,
    output logic [DATA_W-1:0]   dec_key,
    output logic [DATA_W-1:0]   dec_din,
    input  logic                dec_done,
    input  logic [DATA_W-1:0]   dec_dout,
    output logic                core_abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W-1:0]   out_cipher,
    output logic                out_match,
    output logic                out_err,
    output logic [2*STAT_W-1:0] out_stats
);

    state_e              r_state;
    state_e              w_state_next;
    mode_e               r_mode;
    logic [DATA_W-1:0]   r_key;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_cipher;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   r_out_cipher;
    logic                r_out_match;
    logic                r_out_err;
    logic                r_first;
    logic                r_abort;

    logic                w_accept;
    logic                w_enc_fin;
    logic                w_dec_fin;
    logic                w_tmo;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_expire;
    logic                w_out_hs;

    aes_seq_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_first marks the start-pulse cycle of a run state; done is not trusted there.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_enc_fin    = 1'b0;
        w_dec_fin    = 1'b0;
        w_tmo        = 1'b0;
        w_tmr_clr    = 1'b0;
        w_out_hs     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        enc_start    = 1'b0;
        dec_start    = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_tmr_clr = 1'b1;
                    case (mode_e'(in_mode))
                        MODE_ENC, MODE_LOOP: w_state_next = ENC_RUN;
                        MODE_DEC:            w_state_next = DEC_RUN;
                        default:             w_state_next = RESP;
                    endcase
                end
            end
            ENC_RUN: begin
                enc_start = r_first;
                w_tmr_en  = 1'b1;
                if (!r_first && enc_done) begin
                    w_enc_fin = 1'b1;
                    if (r_mode == MODE_LOOP) begin
                        w_state_next = DEC_RUN;
                        w_tmr_clr    = 1'b1;
                    end else begin
                        w_state_next = RESP;
                    end
                end else if (w_expire) begin
                    w_tmo        = 1'b1;
                    w_state_next = RESP;
                end
            end
            DEC_RUN: begin
                dec_start = r_first;
                w_tmr_en  = 1'b1;
                if (!r_first && dec_done) begin
                    w_dec_fin    = 1'b1;
                    w_state_next = RESP;
                end else if (w_expire) begin
                    w_tmo        = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_out_hs     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MODE_ENC;
            r_key        <= '0;
            r_data       <= '0;
            r_cipher     <= '0;
            r_out_data   <= '0;
            r_out_cipher <= '0;
            r_out_match  <= 1'b0;
            r_out_err    <= 1'b0;
            r_first      <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_first <= w_tmr_clr && (w_state_next != RESP);
            r_abort <= w_tmo;
            if (w_accept) begin
                r_mode       <= mode_e'(in_mode);
                r_key        <= in_key;
                r_data       <= in_data;
                r_cipher     <= '0;
                r_out_data   <= '0;
                r_out_cipher <= '0;
                r_out_match  <= 1'b0;
                r_out_err    <= (mode_e'(in_mode) == MODE_RSVD);
            end
            if (w_enc_fin) begin
                r_cipher     <= enc_dout;
                r_out_cipher <= enc_dout;
                if (r_mode == MODE_ENC) begin
                    r_out_data <= enc_dout;
                end
            end
            if (w_dec_fin) begin
                r_out_data  <= dec_dout;
                r_out_match <= (r_mode == MODE_LOOP) && (dec_dout == r_data);
            end
            if (w_tmo) begin
                r_out_err   <= 1'b1;
                r_out_data  <= '0;
                r_out_match <= 1'b0;
            end
        end
    end

    assign enc_key    = r_key;
    assign enc_din    = r_data;
    assign dec_key    = r_key;
    assign dec_din    = (r_mode == MODE_LOOP) ? r_cipher : r_data;
    assign core_abort = r_abort;
    assign out_data   = r_out_data;
    assign out_cipher = r_out_cipher;
    assign out_match  = r_out_match;
    assign out_err    = r_out_err;

`ifdef AES_SEQ_STATS_EN
    logic [STAT_W-1:0] r_pass_cnt;
    logic [STAT_W-1:0] r_fail_cnt;
    logic              w_is_pass;
    logic              w_is_fail;

    assign w_is_pass = (r_mode == MODE_LOOP) && r_out_match && !r_out_err;
    assign w_is_fail = r_out_err || ((r_mode == MODE_LOOP) && !r_out_match);

    // Saturating counters, bumped once per delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (w_out_hs) begin
            if (w_is_pass && (r_pass_cnt != '1)) begin
                r_pass_cnt <= r_pass_cnt + STAT_W'(1);
            end
            if (w_is_fail && (r_fail_cnt != '1)) begin
                r_fail_cnt <= r_fail_cnt + STAT_W'(1);
            end
        end
    end

    assign out_stats = {r_fail_cnt, r_pass_cnt};
`else
    assign out_stats = '0;
`endif

endmodule

// File: doc/aes_seq_ctrl.md
Name: aes_seq_ctrl

Overview:
Parametrised sequencer for the AES encrypt and decrypt cores. It accepts one job per valid/ready handshake in one of three modes: encrypt, decrypt, or loopback (encrypt then decrypt with a self-check). Completion comes from explicit start/done handshakes with the cores, not from watching their outputs. It sits between the system bus-side job interface and the two AES core instances, and adds a timeout, a core abort, and backpressure on results.

Parameters:
DATA_W, 128, block width of plaintext, key and ciphertext
TMO_W, 16, width of the timeout counter
TMO_MAX, 5000, cycles allowed per core operation before timeout (must be < 2**TMO_W)
STAT_W, 16, width of the statistics counters (used only when AES_SEQ_STATS_EN is defined)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  job request
in_ready  out  1  controller can accept a job
in_mode  in  2  0=encrypt, 1=decrypt, 2=loopback, 3=reserved
in_key  in  DATA_W  key
in_data  in  DATA_W  plaintext (modes 0, 2) or ciphertext (mode 1)
enc_start  out  1  one-cycle start pulse to encrypt core
enc_key/enc_din  out  DATA_W  operands held stable from the start pulse until done
enc_done  in  1  one-cycle done pulse from encrypt core
enc_dout  in  DATA_W  encrypt result, valid when enc_done=1
dec_start, dec_key, dec_din, dec_done, dec_dout  same as the enc_* ports, for the decrypt core
core_abort  out  1  one-cycle pulse on timeout; clears the running core
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  encrypt result, decrypt result, or loopback decrypt result
out_cipher  out  DATA_W  intermediate ciphertext (loopback); equals out_data in mode 0, 0 in mode 1
out_match  out  1  loopback only: decrypt result == original plaintext
out_err  out  1  timeout occurred or reserved mode requested
out_stats  out  2*STAT_W  {fail_cnt, pass_cnt}; tied to 0 without the optional feature

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except in_ready=1; internal operand, result and timer registers cleared. Reset asserted mid-job abandons the job with no output; enc_start, dec_start and core_abort are forced low immediately.
- States: IDLE, ENC_RUN, DEC_RUN, RESP.
- IDLE: in_ready=1. When in_valid=1, register key, data and mode.
  - Mode 0 or 2: pulse enc_start next cycle and go to ENC_RUN.
  - Mode 1: pulse dec_start and go to DEC_RUN.
  - Mode 3: go to RESP with out_err=1 and out_data=0.
- Start pulse timing: the start pulse is asserted in the first cycle of the RUN state. The done input is ignored in that cycle; done is sampled from the next cycle.
- ENC_RUN, on enc_done: capture enc_dout into cipher_r.
  - Mode 0 goes to RESP.
  - Mode 2 drives dec_din=cipher_r and goes to DEC_RUN, which pulses dec_start on its first cycle.
- DEC_RUN, on dec_done: capture dec_dout.
  - In mode 2, out_match = (dec_dout == plaintext_r).
  - Go to RESP.
- Timer: cleared on entry to each RUN state and incremented every RUN cycle. If the counter reaches TMO_MAX-1 with no done in that cycle, then on the next cycle:
  - core_abort pulses;
  - out_err=1, out_data=0, out_match=0;
  - state goes to RESP.
  - A done arriving in the same cycle as the limit wins; no timeout is raised.
- RESP: out_valid=1 and all out_* stay stable until out_valid && out_ready. The handshake returns the block to IDLE and clears out_valid. in_ready=0 throughout the job, so there is exactly one job in flight.
- Latency, mode 0: handshake cycle, then the start cycle, then N cycles to done, then out_valid in the cycle after done. No combinational path exists from the done inputs to the out_* ports.
- A done pulse while in IDLE or RESP is ignored.

Optional Feature:
AES_SEQ_STATS_EN
- Defined: pass_cnt and fail_cnt, each STAT_W bits, are updated on every accepted result handshake.
  - pass_cnt increments for a loopback job with out_match=1.
  - fail_cnt increments for any job with out_err=1, or a loopback job with out_match=0.
  - Both saturate at all-ones (no wrap) and clear on reset.
- Undefined: no counters are built and out_stats=0.

Decomposition:
- Package aes_seq_pkg holds:
  - mode encodings MODE_ENC, MODE_DEC, MODE_LOOP, MODE_RSVD;
  - the state enum;
  - default constants for DATA_W and TMO_MAX.
- One sub-module, aes_seq_timer, is natural: parametrised TMO_W/TMO_MAX, with clear and enable inputs and an expire output.

Test Plan:
- Mode 2 with key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff, using behavioural cores with a 12-cycle done. Required: out_cipher=69c4e0d86a7b0430d8cdb78070b4c55a, out_data=pt, out_match=1, out_err=0; with stats enabled, pass_cnt=1.
- Mode 1 with the same key and data=69c4e0d8...c55a. Required: out_data=00112233...eeff, and dec_start pulses exactly once.
- Encrypt core never asserts done, TMO_MAX=20. Required: core_abort pulses exactly once about 20 cycles after enc_start; out_err=1; out_data=0; block back in IDLE after out_ready.
- Mode 3 requested. Required: out_valid the cycle after acceptance with out_err=1; enc_start and dec_start never pulse.
- out_ready held low for 50 cycles. Required: out_* stable, in_ready=0, and a second in_valid is not accepted until the result handshake.
- rst_n dropped during ENC_RUN. Required: the same-cycle async clear gives out_valid=0 and in_ready=1. A late enc_done after reset is ignored, and the next job completes correctly.
